// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x-oversampled UART receiver feeding a first-word-fall-through byte FIFO
// Optional even-parity framing: define UART_RX_PARITY_EN (default build is 8N1, parity_err tied 0).
module uart_rx_fifo #(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               rxPin,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               is_receiving,
  output logic               frame_err,
  output logic               overrun,
  output logic               parity_err
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t          state;
  logic            rxMeta;
  logic            rxSync;
  logic [TW-1:0]   tickCnt;
  logic            tick;
  logic            startDet;
  logic [3:0]      sampleCnt;
  logic [2:0]      bitIdx;
  logic [7:0]      shiftReg;
  logic            bitSample;
  logic            pushNow;
  logic            popNow;
  logic            wrOk;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rxPin;
      rxSync <= rxMeta;
    end
  end

  assign startDet  = (state == IDLE) && !rxSync;
  assign tick      = (tickCnt == TW'(DIV - 1));
  assign bitSample = tick && (sampleCnt == 4'd15);

  // Restarting the divider on start detect keeps every sample at mid-bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)            tickCnt <= '0;
    else if (startDet || tick) tickCnt <= '0;
    else                       tickCnt <= tickCnt + 1'b1;
  end

`ifdef UART_RX_PARITY_EN
  logic parBad;
  assign pushNow = (state == STOP) && bitSample && rxSync && !parBad;
`else
  assign pushNow    = (state == STOP) && bitSample && rxSync;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      sampleCnt    <= '0;
      bitIdx       <= '0;
      shiftReg     <= '0;
      is_receiving <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBad       <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rxSync) begin
            state        <= START;
            sampleCnt    <= '0;
            is_receiving <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (sampleCnt == 4'd7) begin
              sampleCnt <= '0;
              bitIdx    <= '0;
              if (rxSync) begin
                state        <= IDLE;
                is_receiving <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) sampleCnt <= sampleCnt + 1'b1;
          if (bitSample) begin
            shiftReg <= {rxSync, shiftReg[7:1]};
            bitIdx   <= bitIdx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bitIdx == 3'd7) state <= PARITY;
`else
            if (bitIdx == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) sampleCnt <= sampleCnt + 1'b1;
          if (bitSample) begin
            parBad <= rxSync ^ (^shiftReg);
            state  <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) sampleCnt <= sampleCnt + 1'b1;
          if (bitSample) begin
            if (!rxSync) begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end else begin
`ifdef UART_RX_PARITY_EN
              parity_err <= parBad;
`endif
              state        <= IDLE;
              is_receiving <= 1'b0;
            end
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) reports one frame error, then waits for idle.
          if (rxSync) begin
            state        <= IDLE;
            is_receiving <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          is_receiving <= 1'b0;
        end
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW + 1)'(DEPTH));
  assign popNow  = rd_en && !empty;
  assign wrOk    = pushNow && (!full || popNow);
  assign rd_data = mem[rdPtr];

  always_ff @(posedge sys_clk) begin
    if (wrOk) mem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= pushNow && !wrOk;
      if (wrOk)   wrPtr <= wrPtr + 1'b1;
      if (popNow) rdPtr <= rdPtr + 1'b1;
      if (wrOk && !popNow)      count <= count + 1'b1;
      else if (popNow && !wrOk) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo at 224 clocks per bit
module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int BITCLK = 224;
  // Cycle (after the start-bit edge) whose following edge samples the stop bit.
  localparam int PUSHC = 2 + 14 * (8 + 16 * (NBITS - 1));

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       rxPin = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, is_receiving, frame_err, overrun, parity_err;
  logic [4:0] count;

  int total = 0;
  int bad = 0;
  int feCnt = 0, ovCnt = 0, peCnt = 0;
  int snapPre = -1, snapPost = -1;

  uart_rx_fifo dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rxPin(rxPin), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .is_receiving(is_receiving), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (frame_err)  feCnt++;
    if (overrun)    ovCnt++;
    if (parity_err) peCnt++;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic badPar, input bit popAtPush);
    logic [10:0] fr;
`ifdef UART_RX_PARITY_EN
    fr = {stopBit, (^d) ^ badPar, d, 1'b0};
`else
    fr = {badPar, stopBit, d, 1'b0};
`endif
    for (int c = 0; c < NBITS * BITCLK; c++) begin
      if (c == PUSHC)     snapPre  = int'(count);
      if (c == PUSHC + 1) snapPost = int'(count);
      rxPin = fr[c / BITCLK];
      rd_en = popAtPush && (c == PUSHC);
      @(posedge sys_clk); #1;
    end
    rd_en = 1'b0;
  endtask

  task automatic popByte(output logic [7:0] v);
    v = rd_data;
    rd_en = 1'b1;
    @(posedge sys_clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    cycles(3);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if ({is_receiving, frame_err, overrun, parity_err} !== 4'b0)
      begin bad++; $display("FAIL reset_flags: got %b want 0000", {is_receiving, frame_err, overrun, parity_err}); end
    sys_rst_n = 1'b1;
    cycles(5);
  endtask

  task automatic test_single;
    logic [7:0] v;
    sendFrame(8'h55, 1'b1, 1'b0, 1'b0);
    total++; if (snapPre !== 0) begin bad++; $display("FAIL single_pre_push_count: got %0d want 0", snapPre); end
    total++; if (snapPost !== 1) begin bad++; $display("FAIL single_post_push_count: got %0d want 1", snapPost); end
    total++; if (rd_data !== 8'h55) begin bad++; $display("FAIL single_data: got %h want 55", rd_data); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty: got %b want 0", empty); end
    popByte(v);
    total++; if (empty !== 1'b1 || count !== 5'd0)
      begin bad++; $display("FAIL single_after_pop: got empty=%b count=%0d want 1/0", empty, count); end
  endtask

  task automatic test_full;
    int ovB;
    for (int i = 0; i < 16; i++) sendFrame(8'(i), 1'b1, 1'b0, 1'b0);
    total++; if (full !== 1'b1 || count !== 5'd16)
      begin bad++; $display("FAIL full_flag: got full=%b count=%0d want 1/16", full, count); end
    ovB = ovCnt;
    sendFrame(8'hAA, 1'b1, 1'b0, 1'b0);
    total++; if (ovCnt !== ovB + 1) begin bad++; $display("FAIL overrun_pulse: got %0d want %0d", ovCnt, ovB + 1); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL overrun_count: got %0d want 16", count); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL overrun_head: got %h want 00", rd_data); end
  endtask

  task automatic test_back_to_back;
    int ovB;
    logic [7:0] v, exp;
    ovB = ovCnt;
    sendFrame(8'h99, 1'b1, 1'b0, 1'b1);
    total++; if (ovCnt !== ovB) begin bad++; $display("FAIL simul_no_overrun: got %0d want %0d", ovCnt, ovB); end
    total++; if (snapPost !== 16 || count !== 5'd16)
      begin bad++; $display("FAIL simul_count: got %0d/%0d want 16/16", snapPost, count); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(i + 1) : 8'h99;
      popByte(v);
      total++; if (v !== exp) begin bad++; $display("FAIL drain_order[%0d]: got %h want %h", i, v, exp); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_glitch;
    int feB, peB;
    feB = feCnt; peB = peCnt;
    rxPin = 1'b0;
    cycles(10);
    total++; if (is_receiving !== 1'b1) begin bad++; $display("FAIL glitch_detect: got %b want 1", is_receiving); end
    cycles(40);
    rxPin = 1'b1;
    cycles(78);
    total++; if (is_receiving !== 1'b0) begin bad++; $display("FAIL glitch_reject: got %b want 0", is_receiving); end
    total++; if (count !== 5'd0 || feCnt !== feB || peCnt !== peB)
      begin bad++; $display("FAIL glitch_side_effects: got count=%0d fe=%0d pe=%0d want 0/%0d/%0d", count, feCnt, peCnt, feB, peB); end
  endtask

  task automatic test_break;
    int feB;
    logic [7:0] v;
    feB = feCnt;
    sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
    cycles(1000);
    total++; if (feCnt !== feB + 1) begin bad++; $display("FAIL break_frame_err: got %0d want %0d", feCnt, feB + 1); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL break_no_push: got %0d want 0", count); end
    rxPin = 1'b1;
    cycles(30);
    sendFrame(8'h3C, 1'b1, 1'b0, 1'b0);
    total++; if (count !== 5'd1 || rd_data !== 8'h3C)
      begin bad++; $display("FAIL break_recover: got count=%0d data=%h want 1/3c", count, rd_data); end
    total++; if (feCnt !== feB + 1) begin bad++; $display("FAIL break_single_err: got %0d want %0d", feCnt, feB + 1); end
    popByte(v);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] v;
    sendFrame(8'hA1, 1'b1, 1'b0, 1'b0);
    sendFrame(8'hA2, 1'b1, 1'b0, 1'b0);
    sendFrame(8'hA3, 1'b1, 1'b0, 1'b0);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL rst_prefill: got %0d want 3", count); end
    rxPin = 1'b0;
    cycles(BITCLK);
    rxPin = 1'b1;
    cycles(300);
    sys_rst_n = 1'b0;
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || is_receiving !== 1'b0)
      begin bad++; $display("FAIL rst_async: got count=%0d empty=%b rx=%b want 0/1/0", count, empty, is_receiving); end
    cycles(3);
    sys_rst_n = 1'b1;
    cycles(20);
    sendFrame(8'h81, 1'b1, 1'b0, 1'b0);
    total++; if (count !== 5'd1 || rd_data !== 8'h81)
      begin bad++; $display("FAIL rst_next_frame: got count=%0d data=%h want 1/81", count, rd_data); end
    popByte(v);
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int peB, feB;
    peB = peCnt; feB = feCnt;
    sendFrame(8'h81, 1'b1, 1'b1, 1'b0);
    cycles(20);
    total++; if (peCnt !== peB + 1) begin bad++; $display("FAIL parity_pulse: got %0d want %0d", peCnt, peB + 1); end
    total++; if (count !== 5'd0 || feCnt !== feB)
      begin bad++; $display("FAIL parity_discard: got count=%0d fe=%0d want 0/%0d", count, feCnt, feB); end
`else
    total++; if (peCnt !== 0) begin bad++; $display("FAIL parity_tied_low: got %0d pulses want 0", peCnt); end
`endif
  endtask

  initial begin
    cycles(2);
    test_reset;
    test_single;
    test_full;
    test_back_to_back;
    test_glitch;
    test_break;
    test_reset_midframe;
    test_parity;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Stand-alone UART receive path: 16x-oversampled serial deserializer feeding a first-word-fall-through byte FIFO. The consumer pops with a one-cycle read strobe. It provides the receive-side counterpart to the queued transmit path in the UART test top, replacing the bare received/rx_byte pulse with buffered, flow-aware delivery. Framing and overrun faults are reported as single-cycle pulses for LED/status logic.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz.
BAUD, 115200, line rate; oversample divider DIV = CLK_FREQ/(BAUD*16), integer truncation (default 14, so 1 bit = 224 clocks).
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (default 16).

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
sys_rst_n  input  1  asynchronous active-low reset.
rxPin  input  1  asynchronous serial line; idle high.
rd_en  input  1  pop strobe; consumes head byte when empty=0.
rd_data  output  8  head byte, valid while empty=0.
empty  output  1  FIFO holds no bytes.
full  output  1  FIFO holds 2**FIFO_AW bytes.
count  output  FIFO_AW+1  number of stored bytes.
is_receiving  output  1  high from start-bit detect until the frame ends.
frame_err  output  1  1-cycle pulse: stop bit sampled low.
overrun  output  1  1-cycle pulse: valid byte dropped because FIFO full.
parity_err  output  1  1-cycle pulse: parity mismatch (PARITY_EN only; else constant 0).

Behaviour:
- Reset (async, sys_rst_n=0): FSM IDLE; FIFO pointers/count 0; empty=1, full=0, count=0, is_receiving=0, all error pulses 0; synchronizer flops = 1. rd_data undefined while empty. Reset mid-frame aborts: partial byte lost, FIFO cleared.
- rxPin passes a 2-flop synchronizer before use; 2-cycle input latency.
- Tick generator: counter 0..DIV-1, tick when counter==DIV-1. Counter is forced to 0 on start-bit detect so sampling is phase-aligned.
- FSM states: IDLE, START, DATA, (PARITY), STOP, WAIT_IDLE.
- IDLE: synced rx=0 -> START, sample count 0, is_receiving=1.
- START: on 8th tick (mid-bit) sample. If 1 -> IDLE, glitch rejected, no error. If 0 -> DATA.
- DATA: every 16 ticks sample one bit, LSB first, into shift register. After bit 7 -> STOP (or PARITY).
- STOP: after 16 ticks sample. If 1 -> push byte, then IDLE. If 0 -> frame_err pulse, byte discarded, WAIT_IDLE.
- WAIT_IDLE: stays until synced rx=1, then IDLE. Break condition therefore yields exactly one frame_err.
- is_receiving is 0 in IDLE, 1 in all other states.
- Push occurs in the cycle of the stop-bit sample. Byte is visible on rd_data, and empty falls, the next cycle.
- FIFO is FWFT: rd_data = mem[rd_ptr]. rd_en with empty=0 advances rd_ptr; next head appears the following cycle. rd_en with empty=1 is ignored.
- Push while full and no pop: byte dropped, overrun pulse, FIFO unchanged.
- Push and pop in same cycle while full: both performed, count unchanged, no overrun.
- Push and pop in same cycle while empty: push only.
- Pointers are FIFO_AW bits and wrap modulo depth. count = writes - reads, range 0..2**FIFO_AW.

Optional Feature:
UART_RX_PARITY_EN
- Defined: an even-parity bit follows data bit 7 (PARITY state, 16 ticks). If the stop bit is 1 and parity mismatches, parity_err pulses, the byte is discarded and not pushed, and the FSM goes to IDLE. A bad stop bit takes precedence: frame_err only.
- Undefined: 8N1 framing, no PARITY state, parity_err tied 0.

Test Plan:
- Send 0x55 8N1 at 224 clk/bit -> empty falls after the stop sample; rd_data=0x55, count=1; rd_en 1 cycle -> empty=1, count=0.
- Send 16 bytes 0x00..0x0F without popping -> full=1, count=16. Send 0xAA -> overrun pulse, count=16. Pop all -> bytes read 0x00..0x0F in order.
- Start-bit glitch: rxPin low 50 clocks -> no push, no errors, is_receiving returns 0 before 128 clocks.
- Stop bit held low (send 0x3C, then line low 1000 clocks) -> single frame_err pulse, no push; after line returns high, 0x3C -> accepted.
- Full FIFO plus simultaneous rd_en on the push cycle -> no overrun, count stays 16, newest byte read last.
- Assert sys_rst_n=0 mid-byte with 3 bytes buffered -> count=0, empty=1 immediately. Next frame 0x81 -> received correctly. With UART_RX_PARITY_EN, send 0x81 with parity=1 -> parity_err pulse, no push.
